// File: rtl/ioctl_dl_router_pkg.sv
// Shared types and helpers for the ioctl download router: FSM state encoding
// and per-channel slicing of the packed base/size parameter vectors.
package ioctl_pkg;

  localparam int MAX_CH = 64;
  localparam int MAX_AW = 32;
  localparam int VEC_W  = MAX_CH * MAX_AW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dl_state_t;

  // Channel fields are aw bits wide; callers zero-extend the packed vector to VEC_W.
  function automatic logic [MAX_AW-1:0] ch_field(input logic [VEC_W-1:0] vec,
                                                 input int aw, input int i);
    logic [MAX_AW-1:0] mask;
    mask = (aw >= MAX_AW) ? '1 : ((MAX_AW'(1) << aw) - MAX_AW'(1));
    return vec[i*aw +: MAX_AW] & mask;
  endfunction

  function automatic logic [MAX_AW-1:0] ch_base(input logic [VEC_W-1:0] vec,
                                                input int aw, input int i);
    return ch_field(vec, aw, i);
  endfunction

  function automatic logic [MAX_AW-1:0] ch_size(input logic [VEC_W-1:0] vec,
                                                input int aw, input int i);
    return ch_field(vec, aw, i);
  endfunction

endpackage

// File: rtl/ioctl_dl_router_if.sv
// Bundle of the HPS ioctl stream and the core memory write port.
interface ioctl_dl_router_if #(
  parameter int AW = 25,
  parameter int DW = 16
);
  // ioctl side: ioctl_wr is a one-cycle strobe, throttled by a registered
  // ioctl_wait. Memory side: mem_req is a level valid, mem_addr/mem_din hold
  // until the one-cycle mem_ack (ready) completes the transfer.
  logic          ioctl_download;
  logic [7:0]    ioctl_index;
  logic          ioctl_wr;
  logic [AW-1:0] ioctl_addr;
  logic [DW-1:0] ioctl_dout;
  logic          ioctl_wait;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_ack;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    input  ioctl_wait, mem_req, mem_addr, mem_din
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
    output ioctl_wait, mem_req, mem_addr, mem_din
  );
endinterface

// File: rtl/ioctl_dl_router_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
module dl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk_sys) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
endmodule

// File: rtl/ioctl_dl_router.sv
// Multi-channel download front end: latches the channel, rebases and clips
// addresses, optionally byte-swaps, buffers writes and reports completion.
module ioctl_dl_router
  import ioctl_pkg::*;
#(
  parameter int                     NUM_CH     = 4,
  parameter int                     DW         = 16,
  parameter int                     AW         = 25,
  parameter int                     FIFO_DEPTH = 4,
  parameter logic [NUM_CH*AW-1:0]   CH_BASE    = '0,
  parameter logic [NUM_CH*AW-1:0]   CH_SIZE    = '1,
  parameter logic [NUM_CH-1:0]      CH_SWAP    = '0
) (
  input  logic              clk_sys,
  input  logic              reset,
  ioctl_dl_router_if.slave  bus,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] ch_loaded,
  output logic              overflow,
  output logic [5:0]        dl_ch,
  output dl_state_t         dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = AW + DW;
  localparam logic [VEC_W-1:0] BASE_EXT = VEC_W'(CH_BASE);
  localparam logic [VEC_W-1:0] SIZE_EXT = VEC_W'(CH_SIZE);

  dl_state_t         state, state_next;
  logic              dl_taken;
  logic              start;
  logic              ch_valid;
  logic [NUM_CH-1:0] ch_onehot;
  logic [AW-1:0]     cur_base, cur_size;
  logic              cur_swap;
  logic              wr_hit, clip;
  logic [DW-1:0]     swapped, wr_data;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0]     fifo_dout;
  logic [CW-1:0]     fifo_count, count_next;
  logic              wait_force;
  logic              unused_ok;

  // Per-channel parameters for the latched channel; all zero when invalid.
  always_comb begin
    ch_onehot = '0;
    cur_base  = '0;
    cur_size  = '0;
    cur_swap  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (dl_ch == 6'(i)) begin
        ch_onehot[i] = 1'b1;
        cur_base     = AW'(ch_base(BASE_EXT, AW, i));
        cur_size     = AW'(ch_size(SIZE_EXT, AW, i));
        cur_swap     = CH_SWAP[i];
      end
    end
  end

  assign ch_valid = ({1'b0, dl_ch} < 7'(NUM_CH));

  // dl_taken remembers that the current high ioctl_download already started a
  // load, so a rise seen during DRAIN/DONE still starts one once back in IDLE.
  assign start = (state == IDLE) && bus.ioctl_download && !dl_taken;

  assign wr_hit    = (state == LOAD) && bus.ioctl_wr && ch_valid;
  assign fifo_push = wr_hit && (bus.ioctl_addr < cur_size);
  assign clip      = wr_hit && !(bus.ioctl_addr < cur_size);
  assign fifo_pop  = bus.mem_req && bus.mem_ack;

  // Byte reversal is the identity for DW=8, so the swap bit needs no guard.
  assign swapped = {<<8{bus.ioctl_dout}};
  assign wr_data = cur_swap ? swapped : bus.ioctl_dout;

  dl_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_sys (clk_sys),
    .reset   (reset),
    .push    (fifo_push),
    .din     ({cur_base + bus.ioctl_addr, wr_data}),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = LOAD;
      LOAD:    if (!bus.ioctl_download) state_next = DRAIN;
      DRAIN:   if (fifo_empty && !bus.mem_req) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign count_next = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
  assign wait_force = ((state_next == DRAIN) || (state_next == DONE)) && ch_valid;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_taken       <= 1'b0;
      dl_ch          <= '0;
      ch_loaded      <= '0;
      overflow       <= 1'b0;
      bus.ioctl_wait <= 1'b0;
    end else begin
      if (!bus.ioctl_download) dl_taken <= 1'b0;
      else if (start)          dl_taken <= 1'b1;
      if (start) dl_ch <= bus.ioctl_index[5:0];
      if (done)  ch_loaded <= ch_loaded | ch_onehot;
      if (clip)  overflow <= 1'b1;
      // Threshold DEPTH-1 leaves room for the write already in flight as wait rises.
      bus.ioctl_wait <= wait_force || (count_next >= CW'(FIFO_DEPTH - 1));
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      bus.mem_req  <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_din  <= '0;
    end else if (fifo_pop) begin
      bus.mem_req <= 1'b0;
    end else if (!bus.mem_req && !fifo_empty) begin
      bus.mem_req  <= 1'b1;
      bus.mem_addr <= fifo_dout[FW-1:DW];
      bus.mem_din  <= fifo_dout[DW-1:0];
    end
  end

  assign busy      = (state == LOAD) || (state == DRAIN);
  assign done      = (state == DONE) && ch_valid;
  assign dbg_state = state;
  assign unused_ok = &{1'b0, bus.ioctl_index[7:6], fifo_full};
endmodule

// File: tb/tb_ioctl_dl_router.sv
// Directed bench for ioctl_dl_router: memory responder, monitors and a
// scoreboard of expected {mem_addr, mem_din} writes.
module tb_ioctl_dl_router;
  import ioctl_pkg::*;

  localparam int NUM_CH     = 4;
  localparam int DW         = 16;
  localparam int AW         = 25;
  localparam int FIFO_DEPTH = 4;
  localparam logic [NUM_CH*AW-1:0] CH_BASE = {25'h0, 25'h300000, 25'h200000, 25'h100000};
  localparam logic [NUM_CH*AW-1:0] CH_SIZE = {25'h1FFFFFF, 25'h1000, 25'h4, 25'h1FFFFFF};
  localparam logic [NUM_CH-1:0]    CH_SWAP = 4'b0001;

  // clock / reset
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  logic              busy, done, overflow;
  logic [NUM_CH-1:0] ch_loaded;
  logic [5:0]        dl_ch;
  dl_state_t         dbg_state;

  ioctl_dl_router_if #(.AW(AW), .DW(DW)) bus();

  ioctl_dl_router #(
    .NUM_CH(NUM_CH), .DW(DW), .AW(AW), .FIFO_DEPTH(FIFO_DEPTH),
    .CH_BASE(CH_BASE), .CH_SIZE(CH_SIZE), .CH_SWAP(CH_SWAP)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .ch_loaded (ch_loaded),
    .overflow  (overflow),
    .dl_ch     (dl_ch),
    .dbg_state (dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // scoreboard
  logic [AW+DW-1:0] exp_q[$];
  logic [AW+DW-1:0] obs_q[$];
  int obs_rd = 0;

  // responder controls
  bit ack_hold  = 1'b0;
  int ack_delay = 3;

  // monitors
  int   done_cnt      = 0;
  int   req_cnt       = 0;
  int   wait_cnt      = 0;
  int   full_push_cnt = 0;
  logic req_prev      = 1'b0;

  always @(negedge clk_sys) begin
    if (done) done_cnt <= done_cnt + 1;
    if (bus.mem_req && !req_prev) req_cnt <= req_cnt + 1;
    req_prev <= bus.mem_req;
    if (bus.ioctl_wait) wait_cnt <= wait_cnt + 1;
    if (dut.u_fifo.push && dut.u_fifo.full) full_push_cnt <= full_push_cnt + 1;
  end

  // Memory model: acks a request ack_delay cycles after it rises, logging it.
  initial begin
    int age;
    age = 0;
    bus.mem_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (bus.mem_ack) begin
        bus.mem_ack = 1'b0;
      end else if (bus.mem_req && !reset) begin
        age++;
        if (!ack_hold && age >= ack_delay) begin
          obs_q.push_back({bus.mem_addr, bus.mem_din});
          bus.mem_ack = 1'b1;
          age = 0;
        end
      end else begin
        age = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, run=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW+DW-1:0] ent(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {a, d};
  endfunction

  // driver tasks: all enter and leave at a falling edge
  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic wr_raw(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    @(negedge clk_sys);
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    while (bus.ioctl_wait && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    if (n >= 200) check("wr_wait_bound", 64'(bus.ioctl_wait), 64'(0));
    wr_raw(a, d);
  endtask

  task automatic wait_state(input dl_state_t st, input int budget, input string tag);
    for (int i = 0; i < budget && dbg_state != st; i++) @(negedge clk_sys);
    check(tag, 64'(dbg_state), 64'(st));
  endtask

  task automatic start_dl(input logic [7:0] idx, input string tag);
    bus.ioctl_index    = idx;
    bus.ioctl_download = 1'b1;
    @(negedge clk_sys);
    wait_state(LOAD, 20, tag);
  endtask

  task automatic end_dl(input string tag);
    bus.ioctl_download = 1'b0;
    wait_state(IDLE, 400, tag);
  endtask

  task automatic check_mem(input string tag);
    logic [AW+DW-1:0] e;
    int k;
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_rd < obs_q.size()) begin
        check($sformatf("%s_w%0d", tag, k), 64'(obs_q[obs_rd]), 64'(e));
        obs_rd++;
      end else begin
        check($sformatf("%s_missing_w%0d", tag, k), 64'(obs_q.size()), 64'(obs_rd + 1));
      end
      k++;
    end
    check($sformatf("%s_extra", tag), 64'(obs_q.size()), 64'(obs_rd));
    obs_rd = obs_q.size();
  endtask

  initial begin
    int d0, r0, w0;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = '0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = '0;
    bus.ioctl_dout     = '0;

    // reset state
    tick(3);
    check("rst_mem_req",   64'(bus.mem_req),    64'(0));
    check("rst_wait",      64'(bus.ioctl_wait), 64'(0));
    check("rst_busy",      64'(busy),           64'(0));
    check("rst_done",      64'(done),           64'(0));
    check("rst_ch_loaded", 64'(ch_loaded),      64'(0));
    check("rst_overflow",  64'(overflow),       64'(0));
    check("rst_dl_ch",     64'(dl_ch),          64'(0));
    check("rst_state",     64'(dbg_state),      64'(IDLE));
    reset = 1'b0;
    tick(2);

    // channel 0: rebased and byte-swapped
    ack_delay = 3;
    d0 = done_cnt;
    exp_q.push_back(ent(25'h100000, 16'h3412));
    exp_q.push_back(ent(25'h100002, 16'h7856));
    exp_q.push_back(ent(25'h100004, 16'hBC9A));
    start_dl(8'h00, "s1_load");
    check("s1_busy", 64'(busy), 64'(1));
    check("s1_dl_ch", 64'(dl_ch), 64'(0));
    wr(25'h0, 16'h1234);
    wr(25'h2, 16'h5678);
    wr(25'h4, 16'h9ABC);
    end_dl("s1_idle");
    check_mem("s1");
    check("s1_done_once", 64'(done_cnt - d0), 64'(1));
    check("s1_ch_loaded", 64'(ch_loaded),     64'(4'b0001));

    // backpressure on channel 3 with acks withheld
    ack_hold = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(ent(25'(2*k), 16'hA000 + 16'(k)));
    start_dl(8'h03, "s2_load");
    wr_raw(25'h0, 16'hA000);
    wr_raw(25'h2, 16'hA001);
    check("s2_wait_after2", 64'(bus.ioctl_wait), 64'(0));
    wr_raw(25'h4, 16'hA002);
    check("s2_wait_after3", 64'(bus.ioctl_wait), 64'(1));
    wr_raw(25'h6, 16'hA003);
    check("s2_req_held", 64'(bus.mem_req), 64'(1));
    tick(5);
    check("s2_wait_full",    64'(bus.ioctl_wait), 64'(1));
    check("s2_no_writes",    64'(obs_q.size()),   64'(obs_rd));
    check("s2_no_full_push", 64'(full_push_cnt),  64'(0));
    ack_delay = 1;
    ack_hold  = 1'b0;
    end_dl("s2_idle");
    check_mem("s2");
    check("s2_ch_loaded", 64'(ch_loaded), 64'(4'b1001));

    // clipping on channel 1 (size 4), plus request latency
    ack_delay = 3;
    d0 = done_cnt;
    exp_q.push_back(ent(25'h200000, 16'h1111));
    exp_q.push_back(ent(25'h200002, 16'h2222));
    start_dl(8'h01, "s3_load");
    wr_raw(25'h0, 16'h1111);
    check("s3_req_n1", 64'(bus.mem_req), 64'(0));
    tick(1);
    check("s3_req_n2",  64'(bus.mem_req),  64'(1));
    check("s3_req_addr", 64'(bus.mem_addr), 64'(25'h200000));
    wr(25'h2, 16'h2222);
    check("s3_ovf_before", 64'(overflow), 64'(0));
    wr(25'h4, 16'h3333);
    check("s3_ovf_after", 64'(overflow), 64'(1));
    end_dl("s3_idle");
    check_mem("s3");
    check("s3_done_once", 64'(done_cnt - d0), 64'(1));
    check("s3_ch_loaded", 64'(ch_loaded),     64'(4'b1011));

    // invalid channel 7
    d0 = done_cnt;
    r0 = req_cnt;
    w0 = wait_cnt;
    start_dl(8'h07, "s4_load");
    check("s4_dl_ch", 64'(dl_ch), 64'(7));
    for (int k = 0; k < 8; k++) wr_raw(25'(2*k), 16'h5A00 + 16'(k));
    end_dl("s4_idle");
    check("s4_no_req",    64'(req_cnt - r0),  64'(0));
    check("s4_no_wait",   64'(wait_cnt - w0), 64'(0));
    check("s4_no_done",   64'(done_cnt - d0), 64'(0));
    check("s4_ch_loaded", 64'(ch_loaded),     64'(4'b1011));
    check("s4_no_writes", 64'(obs_q.size()),  64'(obs_rd));

    // reset while a request is outstanding
    ack_hold = 1'b1;
    start_dl(8'h00, "s5_load");
    wr_raw(25'h8, 16'hBEEF);
    tick(1);
    check("s5_req_before", 64'(bus.mem_req), 64'(1));
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    tick(1);
    check("s5_rst_req",       64'(bus.mem_req),    64'(0));
    check("s5_rst_wait",      64'(bus.ioctl_wait), 64'(0));
    check("s5_rst_ch_loaded", 64'(ch_loaded),      64'(0));
    check("s5_rst_overflow",  64'(overflow),       64'(0));
    check("s5_rst_busy",      64'(busy),           64'(0));
    check("s5_rst_state",     64'(dbg_state),      64'(IDLE));
    reset    = 1'b0;
    ack_hold = 1'b0;
    ack_delay = 2;
    tick(1);
    d0 = done_cnt;
    exp_q.push_back(ent(25'h100006, 16'hFECA));
    start_dl(8'h00, "s5_load2");
    wr(25'h6, 16'hCAFE);
    end_dl("s5_idle");
    check_mem("s5");
    check("s5_done_once", 64'(done_cnt - d0), 64'(1));
    check("s5_ch_loaded", 64'(ch_loaded),     64'(4'b0001));

    // back-to-back downloads: channel 2 then channel 3
    ack_delay = 3;
    d0 = done_cnt;
    r0 = req_cnt;
    exp_q.push_back(ent(25'h300010, 16'hAAAA));
    exp_q.push_back(ent(25'h300012, 16'h5555));
    start_dl(8'h02, "s6_load1");
    wr(25'h10, 16'hAAAA);
    wr(25'h12, 16'h5555);
    bus.ioctl_download = 1'b0;
    tick(1);
    check("s6_drain",      64'(dbg_state),      64'(DRAIN));
    check("s6_wait_drain", 64'(bus.ioctl_wait), 64'(1));
    bus.ioctl_index    = 8'h03;
    bus.ioctl_download = 1'b1;
    tick(1);
    check("s6_held_off", 64'(dbg_state == LOAD), 64'(0));
    wait_state(LOAD, 100, "s6_load2");
    check("s6_done_first",  64'(done_cnt - d0), 64'(1));
    check("s6_req_first",   64'(req_cnt - r0),  64'(2));
    check("s6_loaded_mid",  64'(ch_loaded),     64'(4'b0101));
    check_mem("s6a");
    exp_q.push_back(ent(25'h000020, 16'h0F0F));
    wr(25'h20, 16'h0F0F);
    end_dl("s6_idle");
    check_mem("s6b");
    check("s6_done_both",  64'(done_cnt - d0), 64'(2));
    check("s6_ch_loaded",  64'(ch_loaded),     64'(4'b1101));
    check("s6_dl_ch",      64'(dl_ch),         64'(3));

    check("no_full_push", 64'(full_push_cnt), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/ioctl_dl_router.md
Name: ioctl_dl_router

Overview:
Synthesizable multi-channel download front end between the HPS ioctl stream and the core memory interface. It replaces ad-hoc per-core load paths and tests like the single-image ROM BIOS preload.
- Latches the target channel from ioctl_index and applies per-channel byte swap.
- Rebases addresses into per-channel memory regions and clips writes past each region's size.
- Buffers words in a small FIFO and throttles the HPS via ioctl_wait.
- Reports per-channel load completion to the core (ROM BIOS, backup RAM image, etc.).

Parameters:
- NUM_CH, 4, number of download channels (1..64).
- DW, 16, ioctl/memory data width in bits; must be 8 or 16.
- AW, 25, ioctl_addr and mem_addr width.
- FIFO_DEPTH, 4, write buffer entries; power of two, minimum 2.
- CH_BASE, 0, packed NUM_CH*AW vector; memory base address of channel i at [i*AW +: AW].
- CH_SIZE, all-ones, packed NUM_CH*AW vector; byte length of channel i's region.
- CH_SWAP, 0, NUM_CH-bit mask; bit i set means swap the bytes of every word for channel i (ignored when DW=8).

Ports:
- clk_sys  in  1  core clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ioctl_download  in  1  download window active.
- ioctl_index  in  8  image index; [5:0] selects the channel, [7:6] are ignored.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  AW  byte offset within the image.
- ioctl_dout  in  DW  write data.
- ioctl_wait  out  1  backpressure to the HPS.
- mem_req  out  1  memory write request, level.
- mem_addr  out  AW  byte address, stable while mem_req is high.
- mem_din  out  DW  data, stable while mem_req is high.
- mem_ack  in  1  one-cycle acknowledge; completes the current request.
- busy  out  1  high in LOAD or DRAIN.
- done  out  1  one-cycle pulse at the end of a download to a valid channel.
- ch_loaded  out  NUM_CH  sticky; bit i is set once channel i has completed a download.
- overflow  out  1  sticky; a write was clipped because offset >= CH_SIZE.
- dl_ch  out  6  latched channel number.

Behaviour:
- Reset: every output is 0, FIFO is empty, FSM is IDLE, all sticky bits are cleared. Reset mid-download abandons any in-flight request immediately; no ack is awaited.
- FSM states: IDLE, LOAD, DRAIN, DONE.
  - IDLE→LOAD on the rising edge of ioctl_download (registered edge detect). ioctl_index[5:0] is latched into dl_ch in that same cycle.
  - LOAD→DRAIN when ioctl_download falls.
  - DRAIN→DONE when the FIFO is empty and mem_req is low.
  - DONE→IDLE after one cycle. In DONE, done=1 and ch_loaded[dl_ch] is set, for valid channels only.
- Invalid channel (dl_ch >= NUM_CH): every write is accepted and discarded, ioctl_wait stays 0, no done pulse.
- Write acceptance in LOAD:
  - ioctl_wr with ioctl_addr >= CH_SIZE[dl_ch] is discarded and sets overflow.
  - Otherwise push {CH_BASE[dl_ch]+ioctl_addr, swapped-or-not data} into the FIFO. The sum wraps modulo 2^AW.
  - ioctl_wr outside LOAD is ignored.
- ioctl_wait is registered.
  - It is 1 when FIFO occupancy after this cycle's push/pop is >= FIFO_DEPTH-1, so one write arriving while wait rises still fits.
  - It is forced to 1 throughout DRAIN and DONE.
  - A push into a full FIFO is a design error; the bench asserts it never occurs.
- Memory side:
  - mem_req rises the cycle after the FIFO becomes non-empty with no request outstanding, i.e. ioctl_wr at cycle N gives mem_req at N+2.
  - mem_addr and mem_din are held until the cycle mem_ack=1. The FIFO pops in that cycle, and mem_req drops for at least one cycle before the next request.
  - mem_ack while mem_req is low is ignored.
  - Simultaneous push and pop leaves occupancy unchanged.
- A new ioctl_download rising edge during DRAIN or DONE is not recognised until IDLE. The HPS is held off by ioctl_wait during those states.
- Byte swap: output data = {d[7:0], d[15:8]} when CH_SWAP[dl_ch] is set and DW=16.

Decomposition:
- Shared package ioctl_pkg: the dl_state_t enum (IDLE, LOAD, DRAIN, DONE) and the helper functions ch_base(i) and ch_size(i) that slice the packed parameters.
- Sub-module dl_fifo: synchronous FIFO, parameters WIDTH and DEPTH, with push, pop, full, empty and count outputs.
- Address compare, swap and FSM live in the top module.

Test Plan:
- Channel 0 (BASE=0x100000, SWAP=1), three words 0x1234, 0x5678, 0x9ABC at offsets 0, 2, 4, mem_ack 3 cycles after each req:
  - mem writes (0x100000, 0x3412), (0x100002, 0x7856), (0x100004, 0xBC9A);
  - done pulses once, ch_loaded=0001.
- Backpressure, FIFO_DEPTH=4, mem_ack tied 0:
  - ioctl_wait=1 after the 3rd write;
  - a 4th write issued in the same cycle wait rises is stored, with no FIFO overflow;
  - releasing mem_ack drains all 4 writes in order.
- Clip, CH_SIZE[1]=4, writes at offsets 0, 2, 4 on channel 1:
  - only 2 mem writes occur, overflow=1, done still pulses.
- Invalid index 7 with NUM_CH=4:
  - 8 writes give no mem_req and ioctl_wait=0 throughout;
  - no done pulse, ch_loaded unchanged.
- Reset asserted while mem_req=1 mid-download:
  - next cycle mem_req=0, ioctl_wait=0, ch_loaded=0, overflow=0, busy=0;
  - a subsequent download completes normally.
- Back-to-back downloads (channel 2, then a new ioctl_download rise 1 cycle after the fall):
  - the second is held off until IDLE;
  - the first done pulses before any second-image mem_req, and ch_loaded ends with both bits set.
